multi_accum: RTL
================

# multi_accum

Parametrised multi-channel accumulator with an independent WIDTH-bit running value per channel. Each valid input applies one operation, ADD, SUB, LOAD or CLEAR, to the addressed channel. Overflow can either wrap or saturate, selected per operation, and each channel keeps a sticky overflow flag. It replaces the single 8-bit add-only accumulator on the lab datapath, where switches and keys drive the inputs and LEDs/HEX displays show the results.

## Interface
- WIDTH, 8, accumulator and data width in bits (≥2)
- CHANNELS, 4, number of independent accumulators (≥1)
- CH_W, derived, max(1, $clog2(CHANNELS)), channel index width
- clk  in  1  rising-edge clock
- clr  in  1  synchronous, active-high reset; overrides all other inputs
- in_valid  in  1  operation strobe, one operation per cycle
- in_ch  in  CH_W  target channel
- in_op  in  2  operation: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- in_data  in  WIDTH  unsigned operand
- sat_en  in  1  1 = saturate, 0 = wrap (ADD/SUB only)
- out_valid  out  1  result strobe
- out_ch  out  CH_W  channel of the reported result
- out_sum  out  WIDTH  channel value after the operation
- out_carry  out  1  carry (ADD) or borrow (SUB) of this operation, before saturation
- ovf_sticky  out  CHANNELS  per-channel sticky overflow flags

## Operation
- All arithmetic is unsigned. The intermediate result is WIDTH+1 bits, with bit WIDTH as the carry or borrow.
- ADD computes {c, s} = acc + in_data.
  - If c=0, the new value is s.
  - If c=1 and sat_en=0, the new value is s (wrap).
  - If c=1 and sat_en=1, the new value is all ones.
- SUB computes {b, s} = acc − in_data, where b=1 when in_data > acc.
  - If b=1 and sat_en=0, the new value is s (mod 2^WIDTH).
  - If b=1 and sat_en=1, the new value is 0.
- LOAD sets acc to in_data. out_carry is 0 and the sticky flag is unchanged.
- CLEAR sets acc to 0 and clears ovf_sticky[in_ch]. out_carry is 0.
- ovf_sticky[ch] is set by any ADD or SUB on ch with carry or borrow equal to 1, in either mode. It stays set until CLEAR on ch or clr.
- If in_ch ≥ CHANNELS, the operation is ignored: no state change and out_valid=0 next cycle.
- sat_en is ignored for LOAD and CLEAR.

## Timing
- Each accumulator is a single-cycle read-modify-write. An operation accepted at edge k updates acc at edge k.
- out_valid, out_ch, out_sum and out_carry are registered. They are valid in the cycle after edge k, for one cycle only.
- When in_valid=0, out_valid=0 next cycle. out_ch, out_sum and out_carry hold their previous values.
- Back-to-back operations on the same channel require no stall. The operation at k+1 sees the value written at k.
- Operations on different channels in consecutive cycles are fully independent.
- A CLEAR and an overflow cannot happen on the same channel in one cycle, because there is one operation per cycle.
- Reset values, taken at the edge where clr=1: every acc=0, ovf_sticky=0, out_valid=0, out_ch=0, out_sum=0, out_carry=0.
- If clr=1 and in_valid=1 in the same cycle, the operation is dropped.
- If clr is asserted mid-stream, the next cycle shows out_valid=0 and all state is zero.

## Structure
- Package accum_pkg holds:
  - op encodings: OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR
  - the in_op width constant
- Sub-module accum_alu is purely combinational.
  - Inputs: acc, in_data, in_op, sat_en.
  - Outputs: next value, carry, and overflow-set.
  - It is parametrised by WIDTH and instantiated once, operating on the channel selected by in_ch.
- The top level contains:
  - the channel register array and its write-enable decode
  - the sticky-flag register
  - the output register stage

## Test plan
- Reset then ADD: pulse clr, then ADD ch0 0x05 → next cycle out_valid=1, out_ch=0, out_sum=0x05, out_carry=0, ovf_sticky=0000.
- Wrap: LOAD ch1 0xF0, then ADD ch1 0x20 with sat_en=0 → out_sum=0x10, out_carry=1, ovf_sticky[1]=1. Then ADD ch1 0x01 → out_sum=0x11, out_carry=0, sticky still 1.
- Saturate:
  - LOAD ch2 0xF0, then ADD ch2 0x20 with sat_en=1 → out_sum=0xFF, out_carry=1.
  - LOAD ch2 0x10, then SUB ch2 0x20 with sat_en=1 → out_sum=0x00, out_carry=1.
  - ovf_sticky[2]=1 after each.
- Channel independence and back-to-back: ADD ch0 0x01, ADD ch3 0x02, ADD ch0 0x01, ADD ch3 0x02 on consecutive cycles → out_sum sequence 0x01, 0x02, 0x02, 0x04 with out_ch 0, 3, 0, 3, and out_valid high on four consecutive cycles.
- CLEAR and invalid channel:
  - CLEAR ch1 after the wrap test → out_sum=0x00, ovf_sticky[1]=0.
  - With CHANNELS=3, an ADD on ch3 → out_valid=0 and no channel changes.
- Reset mid-stream: clr=1 together with in_valid (ADD ch0 0x7F) while ch0=0x10 → next cycle out_valid=0. A following ADD ch0 0x00 → out_sum=0x00.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the multi-channel accumulator: operation encodings and widths.
package accum_pkg;

  // Width of the operation select field
  localparam int unsigned OP_W = 2;

  // Operation encodings
  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } accum_op_e;

endpackage

// File: rtl/accum_alu.sv
// Combinational next-value logic for one accumulator channel.
// Computes ADD/SUB with wrap or saturate, LOAD and CLEAR, plus carry/borrow and
// the overflow indication used to set the sticky flag.
module accum_alu
  import accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             sat_en_i,
  output logic [WIDTH-1:0] next_o,
  output logic             carry_o,
  output logic             ovf_set_o
);

  accum_op_e      op;
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] dif_ext;

  assign op = accum_op_e'(op_i);

  // Zero-extended add and subtract; bit WIDTH is carry (add) or borrow (sub).
  // The borrow bit is set exactly when data_i > acc_i.
  assign sum_ext = {1'b0, acc_i} + {1'b0, data_i};
  assign dif_ext = {1'b0, acc_i} - {1'b0, data_i};

  // Select the result per operation; saturation only affects ADD/SUB
  always_comb begin
    next_o    = acc_i;
    carry_o   = 1'b0;
    ovf_set_o = 1'b0;
    unique case (op)
      OP_ADD: begin
        carry_o   = sum_ext[WIDTH];
        ovf_set_o = sum_ext[WIDTH];
        next_o    = (sum_ext[WIDTH] && sat_en_i) ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
      end
      OP_SUB: begin
        carry_o   = dif_ext[WIDTH];
        ovf_set_o = dif_ext[WIDTH];
        next_o    = (dif_ext[WIDTH] && sat_en_i) ? {WIDTH{1'b0}} : dif_ext[WIDTH-1:0];
      end
      OP_LOAD: begin
        next_o = data_i;
      end
      OP_CLEAR: begin
        next_o = {WIDTH{1'b0}};
      end
      default: begin
        next_o = acc_i;
      end
    endcase
  end

endmodule

// File: rtl/multi_accum.sv
// Multi-channel accumulator. One shared ALU works on the channel addressed by in_ch;
// the result is written back in the same cycle and reported through a registered
// output stage one cycle later. Each channel keeps a sticky overflow flag.
module multi_accum
  import accum_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [OP_W-1:0]     in_op,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                sat_en,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [WIDTH-1:0]    out_sum,
  output logic                out_carry,
  output logic [CHANNELS-1:0] ovf_sticky
);

  logic [WIDTH-1:0]    acc_q [CHANNELS];
  logic [WIDTH-1:0]    acc_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [WIDTH-1:0]    out_sum_q, out_sum_d;
  logic                out_carry_q, out_carry_d;

  logic [WIDTH-1:0]    acc_sel;
  logic                ch_ok;
  logic                we;
  logic [WIDTH-1:0]    alu_next;
  logic                alu_carry;
  logic                alu_ovf;

  // Read mux; looping over real channels keeps an out-of-range in_ch from indexing
  // past the array and doubles as the channel range check.
  always_comb begin
    acc_sel = '0;
    ch_ok   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i)) begin
        acc_sel = acc_q[i];
        ch_ok   = 1'b1;
      end
    end
  end

  assign we = in_valid && ch_ok;

  accum_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .acc_i     (acc_sel),
    .data_i    (in_data),
    .op_i      (in_op),
    .sat_en_i  (sat_en),
    .next_o    (alu_next),
    .carry_o   (alu_carry),
    .ovf_set_o (alu_ovf)
  );

  // Write-enable decode for the channel array and sticky flags
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      acc_d[i] = acc_q[i];
      if (we && (in_ch == CH_W'(i))) begin
        acc_d[i] = alu_next;
        if (accum_op_e'(in_op) == OP_CLEAR) begin
          ovf_d[i] = 1'b0;
        end else if (alu_ovf) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Output stage next state; data fields hold when no operation is accepted
  always_comb begin
    out_valid_d = we;
    out_ch_d    = out_ch_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    if (we) begin
      out_ch_d    = in_ch;
      out_sum_d   = alu_next;
      out_carry_d = alu_carry;
    end
  end

  // State update with synchronous clear overriding any operation
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= acc_d[i];
      end
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_sum    = out_sum_q;
  assign out_carry  = out_carry_q;
  assign ovf_sticky = ovf_q;

endmodule
